rupt_ctrl: RTL and testbench

- Interrupt (RUPT) scheduler for the AGC pipeline.
- Latches requests from timer, keyboard, uplink, downlink, radar and hand-controller sources, and picks the highest-priority pending one.
- Takes the interrupt only at a safe instruction boundary: never between EXTEND or INDEX and the following instruction, never while inhibited, never while A holds overflow.
- Sequences the decode/fetch stages via flush plus PC redirect, both on entry and on RESUME.

---
 rtl/rupt_pkg.sv | 33 +++
 rtl/rupt_prio_enc.sv | 26 ++
 rtl/rupt_ctrl.sv | 158 +++++++++++++++
 tb/tb_rupt_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rupt_pkg.sv
// Shared types, source indices and vector arithmetic for the RUPT scheduler.
// Optional build macro: RUPT_LOCK_EN (service watchdog in rupt_ctrl).
package rupt_pkg;

  localparam int N_RUPT_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERVICE,
    RETURN
  } rupt_state_t;

  // Source indices; lower index means higher priority.
  localparam int T6RUPT    = 0;
  localparam int T5RUPT    = 1;
  localparam int T3RUPT    = 2;
  localparam int T4RUPT    = 3;
  localparam int KEYRUPT1  = 4;
  localparam int KEYRUPT2  = 5;
  localparam int UPRUPT    = 6;
  localparam int DOWNRUPT  = 7;
  localparam int RADARRUPT = 8;
  localparam int HANDRUPT  = 9;

  // Vector address of a source, wrapped to the 12-bit address space.
  function automatic logic [11:0] rupt_vector(input logic [11:0] base,
                                              input int          stride,
                                              input int          idx);
    return base + 12'(stride * idx);
  endfunction

endpackage

// File: rtl/rupt_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module rupt_prio_enc #(
  parameter int N  = 10,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid  = |req;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rupt_ctrl.sv
// RUPT scheduler: latches request edges, takes the highest-priority one at a
// safe boundary and sequences flush/redirect on entry and RESUME. Macro: RUPT_LOCK_EN.
module rupt_ctrl
  import rupt_pkg::*;
#(
  parameter int          N_RUPT           = N_RUPT_DEFAULT,
  parameter logic [11:0] VEC_BASE         = 12'o4000,
  parameter int          VEC_STRIDE       = 4,
  parameter int          RUPT_LOCK_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [N_RUPT-1:0] rupt_req,
  input  logic              instr_valid,
  input  logic              extend_pend,
  input  logic              index_pend,
  input  logic              ovf_a,
  input  logic              inhint,
  input  logic              relint,
  input  logic              resume,
  input  logic [11:0]       pc_next,
  output logic              flush,
  output logic              redirect_en,
  output logic [11:0]       redirect_pc,
  output logic              in_isr,
  output logic [N_RUPT-1:0] pending,
  output logic [N_RUPT-1:0] ack,
  output logic              rupt_lock,
  output rupt_state_t       state_dbg
);

  localparam int IW = (N_RUPT > 1) ? $clog2(N_RUPT) : 1;

  // Handshake-free block: every input is a level or a single-cycle pulse
  // sampled on the rising clock; ack/flush/redirect are same-cycle strobes.

  rupt_state_t       state, state_nxt;
  logic [N_RUPT-1:0] req_q;
  logic [N_RUPT-1:0] pend_q;
  logic [N_RUPT-1:0] rise;
  logic [N_RUPT-1:0] pend_clr;
  logic              inhibit_q;
  logic [11:0]       saved_pc_q;
  logic              prio_valid;
  logic [IW-1:0]     prio_idx;
  logic [N_RUPT-1:0] prio_onehot;
  logic              take_ok;
  logic              force_ret;

  rupt_prio_enc #(.N(N_RUPT), .IW(IW)) u_prio (
    .req    (pend_q),
    .valid  (prio_valid),
    .idx    (prio_idx),
    .onehot (prio_onehot)
  );

  assign rise    = rupt_req & ~req_q;
  assign take_ok = (state == IDLE) & instr_valid & prio_valid & ~inhibit_q
                 & ~extend_pend & ~index_pend & ~ovf_a;

  // A new edge on the same bit being acked this cycle stays pending.
  always_ff @(posedge clock) begin
    if (rst) begin
      req_q      <= '0;
      pend_q     <= '0;
      inhibit_q  <= 1'b0;
      saved_pc_q <= '0;
      state      <= IDLE;
    end else begin
      req_q  <= rupt_req;
      pend_q <= (pend_q & ~pend_clr) | rise;
      if (inhint) begin
        inhibit_q <= 1'b1;
      end else if (relint) begin
        inhibit_q <= 1'b0;
      end
      if (take_ok) begin
        saved_pc_q <= pc_next;
      end
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    in_isr      = 1'b0;
    ack         = '0;
    pend_clr    = '0;
    case (state)
      IDLE: begin
        if (take_ok) begin
          state_nxt   = TAKE;
          flush       = 1'b1;
          redirect_en = 1'b1;
          redirect_pc = rupt_vector(VEC_BASE, VEC_STRIDE, int'(prio_idx));
          ack         = prio_onehot;
          pend_clr    = prio_onehot;
        end
      end
      TAKE: begin
        in_isr    = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: begin
        in_isr = 1'b1;
        if (resume || force_ret) begin
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        in_isr      = 1'b1;
        flush       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = saved_pc_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RUPT_LOCK_EN
  localparam int CW = (RUPT_LOCK_CYCLES > 2) ? $clog2(RUPT_LOCK_CYCLES) : 1;

  logic [CW-1:0] lock_cnt;
  logic          lock_q;

  // Counter restarts on every entry so each ISR gets the full budget.
  always_ff @(posedge clock) begin
    if (rst) begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end else begin
      if (state_nxt == TAKE) begin
        lock_cnt <= '0;
      end else if (state == SERVICE) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      lock_q <= force_ret;
    end
  end

  assign force_ret = (state == SERVICE) & ~resume
                   & (lock_cnt == CW'(RUPT_LOCK_CYCLES - 1));
  assign rupt_lock = lock_q;
`else
  localparam int unused_lock_cycles = RUPT_LOCK_CYCLES;

  assign force_ret = 1'b0;
  assign rupt_lock = 1'b0;
`endif

  assign pending   = pend_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_rupt_ctrl.sv
// Self-checking bench for rupt_ctrl: scenario tasks plus an ack/vector scoreboard.
module tb_rupt_ctrl;
  import rupt_pkg::*;

`ifdef RUPT_LOCK_EN
  localparam int LOCK_CYC = 8;
`else
  localparam int LOCK_CYC = 1024;
`endif
  localparam int N = 10;

  logic          clock = 1'b0;
  logic          rst;
  logic [N-1:0]  rupt_req;
  logic          instr_valid, extend_pend, index_pend, ovf_a;
  logic          inhint, relint, resume;
  logic [11:0]   pc_next;
  logic          flush, redirect_en, in_isr, rupt_lock;
  logic [11:0]   redirect_pc;
  logic [N-1:0]  pending, ack;
  rupt_state_t   state_dbg;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [N+11:0] exp_q[$];

  rupt_ctrl #(.N_RUPT(N), .VEC_BASE(12'o4000), .VEC_STRIDE(4),
              .RUPT_LOCK_CYCLES(LOCK_CYC)) dut (
    .clock(clock), .rst(rst), .rupt_req(rupt_req), .instr_valid(instr_valid),
    .extend_pend(extend_pend), .index_pend(index_pend), .ovf_a(ovf_a),
    .inhint(inhint), .relint(relint), .resume(resume), .pc_next(pc_next),
    .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .in_isr(in_isr), .pending(pending), .ack(ack), .rupt_lock(rupt_lock),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Scoreboard: every take must match the oldest expected {ack, vector}.
  always @(negedge clock) begin
    logic [N+11:0] exp_item;
    if (mon_en && !rst && ack !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack: ack=%h pc=%o, required no ack", ack, redirect_pc);
      end else begin
        exp_item = exp_q.pop_front();
        if ({ack, redirect_pc} !== exp_item || flush !== 1'b1 || redirect_en !== 1'b1) begin
          errors++;
          $display("FAIL sb_take: ack=%h pc=%o flush=%b ren=%b, required ack=%h pc=%o flush=1 ren=1",
                   ack, redirect_pc, flush, redirect_en, exp_item[N+11:12], exp_item[11:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic wait_service();
    int n = 0;
    while (state_dbg !== SERVICE && n < 20) begin
      tick();
      sample();
      n++;
    end
    checks++;
    if (state_dbg !== SERVICE) begin
      errors++;
      $display("FAIL service_timeout: state=%0d, required %0d", state_dbg, SERVICE);
    end
  endtask

  // Caller has just sampled a SERVICE cycle.
  task automatic do_resume(input logic [11:0] exp_pc);
    tick();
    resume = 1'b1;
    sample();
    tick();
    resume = 1'b0;
    sample();
    checks++;
    if (state_dbg !== RETURN || flush !== 1'b1 || redirect_en !== 1'b1 ||
        redirect_pc !== exp_pc || in_isr !== 1'b1) begin
      errors++;
      $display("FAIL return_cycle: state=%0d flush=%b ren=%b pc=%o isr=%b, required state=%0d flush=1 ren=1 pc=%o isr=1",
               state_dbg, flush, redirect_en, redirect_pc, in_isr, RETURN, exp_pc);
    end
    tick();
    sample();
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL return_to_idle: state=%0d, required %0d", state_dbg, IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rupt_req = '0; instr_valid = 1'b0; extend_pend = 1'b0; index_pend = 1'b0;
    ovf_a = 1'b0; inhint = 1'b0; relint = 1'b0; resume = 1'b0; pc_next = '0;
    repeat (3) tick();
    sample();
    checks++;
    if (flush !== 1'b0 || redirect_en !== 1'b0 || redirect_pc !== 12'o0 || in_isr !== 1'b0 ||
        pending !== '0 || ack !== '0 || rupt_lock !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_values: flush=%b ren=%b pc=%o isr=%b pend=%h ack=%h lock=%b state=%0d, required all 0",
               flush, redirect_en, redirect_pc, in_isr, pending, ack, rupt_lock, state_dbg);
    end
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    sample();
  endtask

  task automatic test_single();
    tick();
    rupt_req[T4RUPT] = 1'b1; instr_valid = 1'b1; pc_next = 12'o1234;
    sample();
    checks++;
    if (pending !== '0 || ack !== '0) begin
      errors++;
      $display("FAIL single_edge_cycle: pend=%h ack=%h, required 0 0", pending, ack);
    end
    exp_q.push_back({10'h008, 12'o4014});
    tick();
    sample();
    checks++;
    if (pending !== 10'h008 || ack !== 10'h008 || flush !== 1'b1 || redirect_pc !== 12'o4014) begin
      errors++;
      $display("FAIL single_take: pend=%h ack=%h flush=%b pc=%o, required 008 008 1 4014",
               pending, ack, flush, redirect_pc);
    end
    tick();
    sample();
    checks++;
    if (state_dbg !== TAKE || in_isr !== 1'b1 || flush !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL single_take_state: state=%0d isr=%b flush=%b pend=%h, required %0d 1 0 000",
               state_dbg, in_isr, flush, pending, TAKE);
    end
    wait_service();
    do_resume(12'o1234);
    rupt_req = '0;
  endtask

  task automatic test_two_same();
    tick();
    rupt_req[T3RUPT] = 1'b1; rupt_req[KEYRUPT2] = 1'b1; pc_next = 12'o0100;
    exp_q.push_back({10'h004, 12'o4010});
    exp_q.push_back({10'h020, 12'o4024});
    sample();
    tick();
    sample();
    checks++;
    if (ack !== 10'h004) begin
      errors++;
      $display("FAIL two_first_ack: ack=%h, required 004", ack);
    end
    tick();
    sample();
    checks++;
    if (pending !== 10'h020) begin
      errors++;
      $display("FAIL two_pending_left: pend=%h, required 020", pending);
    end
    wait_service();
    do_resume(12'o0100);
    checks++;
    if (ack !== 10'h020) begin
      errors++;
      $display("FAIL two_second_ack: ack=%h, required 020", ack);
    end
    wait_service();
    do_resume(12'o0100);
    rupt_req = '0;
  endtask

  task automatic test_gates();
    for (int g = 0; g < 3; g++) begin
      tick();
      extend_pend = (g == 0); index_pend = (g == 1); ovf_a = (g == 2);
      rupt_req[T6RUPT] = 1'b1; pc_next = 12'o0300 + 12'(g);
      sample();
      for (int k = 0; k < 3; k++) begin
        tick();
        sample();
        checks++;
        if (ack !== '0 || pending[T6RUPT] !== 1'b1) begin
          errors++;
          $display("FAIL gate%0d_hold: ack=%h pend=%h, required ack 000 pend bit0 set", g, ack, pending);
        end
      end
      tick();
      extend_pend = 1'b0; index_pend = 1'b0; ovf_a = 1'b0;
      exp_q.push_back({10'h001, 12'o4000});
      sample();
      checks++;
      if (ack !== 10'h001 || redirect_pc !== 12'o4000) begin
        errors++;
        $display("FAIL gate%0d_release: ack=%h pc=%o, required 001 4000", g, ack, redirect_pc);
      end
      wait_service();
      do_resume(12'o0300 + 12'(g));
      rupt_req = '0;
    end
  endtask

  task automatic test_inhibit();
    tick();
    instr_valid = 1'b0; rupt_req[KEYRUPT1] = 1'b1; pc_next = 12'o0400;
    sample();
    tick();
    sample();
    checks++;
    if (pending !== 10'h010) begin
      errors++;
      $display("FAIL inh_pending: pend=%h, required 010", pending);
    end
    tick();
    inhint = 1'b1; relint = 1'b1;
    sample();
    tick();
    inhint = 1'b0; relint = 1'b0; instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if (ack !== '0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL inh_blocks: ack=%h flush=%b, required 000 0", ack, flush);
      end
      tick();
    end
    relint = 1'b1;
    sample();
    checks++;
    if (ack !== '0) begin
      errors++;
      $display("FAIL inh_relint_cycle: ack=%h, required 000", ack);
    end
    tick();
    relint = 1'b0;
    exp_q.push_back({10'h010, 12'o4020});
    sample();
    checks++;
    if (ack !== 10'h010) begin
      errors++;
      $display("FAIL inh_release_take: ack=%h, required 010", ack);
    end
    wait_service();
    do_resume(12'o0400);
    rupt_req = '0;
  endtask

  task automatic test_resume_nested();
    tick();
    resume = 1'b1;
    sample();
    tick();
    resume = 1'b0;
    sample();
    checks++;
    if (state_dbg !== IDLE || flush !== 1'b0 || redirect_en !== 1'b0) begin
      errors++;
      $display("FAIL resume_idle_ignored: state=%0d flush=%b ren=%b, required %0d 0 0",
               state_dbg, flush, redirect_en, IDLE);
    end
    tick();
    rupt_req[HANDRUPT] = 1'b1; pc_next = 12'o2345;
    exp_q.push_back({10'h200, 12'o4044});
    sample();
    wait_service();
    tick();
    rupt_req[T5RUPT] = 1'b1;
    sample();
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      checks++;
      if (ack !== '0 || pending !== 10'h002 || state_dbg !== SERVICE) begin
        errors++;
        $display("FAIL nested_held: ack=%h pend=%h state=%0d, required 000 002 %0d",
                 ack, pending, state_dbg, SERVICE);
      end
    end
    exp_q.push_back({10'h002, 12'o4004});
    do_resume(12'o2345);
    checks++;
    if (ack !== 10'h002) begin
      errors++;
      $display("FAIL nested_after_return: ack=%h, required 002", ack);
    end
    wait_service();
    do_resume(12'o2345);
    rupt_req = '0;
  endtask

  task automatic test_service_hold();
    int pulses = 0;
    tick();
    rupt_req[UPRUPT] = 1'b1; pc_next = 12'o0600;
    exp_q.push_back({10'h040, 12'o4030});
    sample();
    wait_service();
`ifdef RUPT_LOCK_EN
    for (int k = 0; k < LOCK_CYC + 6; k++) begin
      tick();
      sample();
      if (rupt_lock === 1'b1) begin
        pulses++;
        checks++;
        if (state_dbg !== RETURN || redirect_pc !== 12'o0600 || flush !== 1'b1) begin
          errors++;
          $display("FAIL lock_forced_return: state=%0d pc=%o flush=%b, required %0d 0600 1",
                   state_dbg, redirect_pc, flush, RETURN);
        end
      end
    end
    checks++;
    if (pulses != 1 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL lock_pulse_count: pulses=%0d state=%0d, required 1 %0d", pulses, state_dbg, IDLE);
    end
`else
    for (int k = 0; k < 105; k++) begin
      tick();
      sample();
      if (state_dbg !== SERVICE || rupt_lock !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL service_hold: bad_cycles=%0d, required 0 (SERVICE, rupt_lock=0)", pulses);
    end
    do_resume(12'o0600);
`endif
    rupt_req = '0;
  endtask

  task automatic test_reset_mid();
    tick();
    rupt_req[DOWNRUPT] = 1'b1; pc_next = 12'o0700;
    exp_q.push_back({10'h080, 12'o4034});
    sample();
    wait_service();
    tick();
    rupt_req[RADARRUPT] = 1'b1;
    sample();
    tick();
    rst = 1'b1; rupt_req = '0;
    sample();
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if (state_dbg !== IDLE || pending !== '0 || flush !== 1'b0 || redirect_en !== 1'b0 ||
        in_isr !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL reset_mid_isr: state=%0d pend=%h flush=%b ren=%b isr=%b ack=%h, required IDLE and all 0",
               state_dbg, pending, flush, redirect_en, in_isr, ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_same();
    test_gates();
    test_inhibit();
    test_resume_nested();
    test_service_hold();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing_acks: outstanding=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
